// File: rtl/video_pixel_sampler.sv
// Inline RGB565 stream sniffer: tracks raster x/y and captures the pixel at (sample_x, sample_y).
// Optional two-pixel horizontal averaging is enabled by defining VIDEO_PIXEL_SAMPLER_AVG_EN.
module video_pixel_sampler #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   in_data,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          in_eop,
    output logic          in_ready,
    output logic [15:0]   out_data,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    input  logic          out_ready,
    input  logic [XW-1:0] sample_x,
    input  logic [YW-1:0] sample_y,
    output logic [15:0]   pixel_out,
    output logic          pixel_valid,
    output logic          frame_err,
    output logic [7:0]    frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT_SOP
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x, cur_x;
    logic [YW-1:0] y, cur_y;
    logic          beat, in_frame, last_pix, last_col, hit;

    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign out_sop   = in_sop;
    assign out_eop   = in_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Every in-frame beat ends the frame on eop, parks after an eop-less last pixel, else stays active.
    always_comb begin
        state_nxt = state;
        if (in_frame) begin
            if (in_eop)        state_nxt = IDLE;
            else if (last_pix) state_nxt = WAIT_SOP;
            else               state_nxt = ACTIVE;
        end
    end

    always_comb begin
        beat     = in_valid && out_ready;
        in_frame = beat && (in_sop || (state == ACTIVE));
        cur_x    = in_sop ? '0 : x;
        cur_y    = in_sop ? '0 : y;
        last_col = (cur_x == XW'(WIDTH - 1));
        last_pix = last_col && (cur_y == YW'(HEIGHT - 1));
        hit      = in_frame && (cur_x == sample_x) && (cur_y == sample_y);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else if (in_frame) begin
            if (last_col) begin
                x <= '0;
                y <= cur_y + 1'b1;
            end else begin
                x <= cur_x + 1'b1;
                y <= cur_y;
            end
            if ((in_sop && state == ACTIVE) || (in_eop != last_pix))
                frame_err <= 1'b1;
            if (in_eop)
                frame_count <= frame_count + 8'd1;
        end
    end

`ifdef VIDEO_PIXEL_SAMPLER_AVG_EN
    logic [15:0] stage;
    logic        pend;
    logic [5:0]  r_sum, b_sum;
    logic [6:0]  g_sum;

    always_comb begin
        r_sum = {1'b0, stage[15:11]} + {1'b0, in_data[15:11]};
        g_sum = {1'b0, stage[10:5]}  + {1'b0, in_data[10:5]};
        b_sum = {1'b0, stage[4:0]}   + {1'b0, in_data[4:0]};
    end

    // A staged pixel pairs with the very next in-frame beat; a restart commits it raw instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage       <= '0;
            pend        <= 1'b0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else if (in_frame) begin
            if (pend) begin
                pend        <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_out   <= in_sop ? stage : {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
            end
            if (hit) begin
                if (last_col || in_eop) begin
                    pixel_out   <= in_data;
                    pixel_valid <= 1'b1;
                end else begin
                    stage <= in_data;
                    pend  <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else if (hit) begin
            pixel_out   <= in_data;
            pixel_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_video_pixel_sampler.sv
// Directed self-checking bench for video_pixel_sampler on a reduced 16x10 raster.
module tb_video_pixel_sampler;

    localparam int W = 16;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready;
    logic [8:0]  sample_x;
    logic [7:0]  sample_y;
    logic [15:0] pixel_out;
    logic        pixel_valid, frame_err;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;
    bit rdy_phase = 1'b0;

    video_pixel_sampler #(.WIDTH(W), .HEIGHT(H), .XW(9), .YW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .sample_x(sample_x), .sample_y(sample_y),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset_n = 1'b0;
        in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_state(input string name, input logic [15:0] exp_pix, input logic exp_pv,
                               input logic exp_err, input logic [7:0] exp_cnt);
        checks++;
        if ({pixel_out, pixel_valid, frame_err, frame_count} !== {exp_pix, exp_pv, exp_err, exp_cnt}) begin
            failures++;
            $display("FAIL %s: got pix=%h pv=%b err=%b cnt=%0d, expected pix=%h pv=%b err=%b cnt=%0d",
                     name, pixel_out, pixel_valid, frame_err, frame_count, exp_pix, exp_pv, exp_err, exp_cnt);
        end
    endtask

    // One accepted beat; with tog, out_ready alternates and the pass-through is checked every cycle.
    task automatic drive_beat(input logic [15:0] d, input logic sop, input logic eop, input bit tog);
        bit done = 1'b0;
        while (!done) begin
            in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
            out_ready = tog ? rdy_phase : 1'b1;
            if (tog) rdy_phase = ~rdy_phase;
            #1;
            if (tog) begin
                checks++;
                if ({in_ready, out_data, out_valid, out_sop, out_eop} !==
                    {out_ready, d, 1'b1, sop, eop}) begin
                    failures++;
                    $display("FAIL passthrough: got rdy=%b d=%h v=%b s=%b e=%b, expected rdy=%b d=%h v=1 s=%b e=%b",
                             in_ready, out_data, out_valid, out_sop, out_eop, out_ready, d, sop, eop);
                end
            end
            done = out_ready;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int n, input bit eop_last, input logic [15:0] tag, input bit tog);
        for (int i = 0; i < n; i++) begin
            logic [7:0] xb, yb;
            xb = 8'(i % W);
            yb = 8'(i / W);
            drive_beat({yb, xb} ^ tag, i == 0, eop_last && (i == n - 1), tog);
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        check_state("reset_values", 16'h0000, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_basic_capture();
        apply_reset();
        sample_x = 9'd5; sample_y = 8'd3;
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        check_state("basic_capture", 16'h0305, 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_backpressure();
        apply_reset();
        sample_x = 9'd7; sample_y = 8'd2;
        send_frame(W * H, 1'b1, 16'h0000, 1'b1);
        check_state("toggled_ready", 16'h0207, 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_early_eop();
        apply_reset();
        sample_x = 9'(W - 1); sample_y = 8'(H - 1);
        send_frame(2 * W + 10 + 1, 1'b1, 16'h0000, 1'b0);
        check_state("early_eop", 16'h0000, 1'b0, 1'b1, 8'd1);
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        check_state("last_pixel_after_err", 16'h090F, 1'b1, 1'b1, 8'd2);
    endtask

    task automatic test_restart();
        apply_reset();
        sample_x = 9'd3; sample_y = 8'd1;
        send_frame(5 * W + 10, 1'b0, 16'h8000, 1'b0);
        check_state("pre_restart_capture", 16'h8103, 1'b1, 1'b0, 8'd0);
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        check_state("restart_capture", 16'h0103, 1'b1, 1'b1, 8'd1);
    endtask

    task automatic test_late_eop();
        apply_reset();
        sample_x = 9'd0; sample_y = 8'd0;
        send_frame(W * H, 1'b0, 16'h4000, 1'b0);
        check_state("late_eop", 16'h4000, 1'b1, 1'b1, 8'd0);
        drive_beat(16'h5555, 1'b0, 1'b0, 1'b0);
        drive_beat(16'h6666, 1'b0, 1'b1, 1'b0);
        check_state("wait_sop_ignores", 16'h4000, 1'b1, 1'b1, 8'd0);
        drive_beat(16'h1234, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check_state("sop_after_wait", 16'h1234, 1'b1, 1'b1, 8'd0);
    endtask

    task automatic test_one_pixel_frame();
        apply_reset();
        sample_x = 9'd1; sample_y = 8'd0;
        drive_beat(16'h0F0F, 1'b1, 1'b1, 1'b0);
        drive_beat(16'hAAAA, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check_state("sop_eop_same_beat", 16'h0000, 1'b0, 1'b1, 8'd1);
    endtask

    task automatic test_out_of_range_and_reset();
        apply_reset();
        sample_x = 9'd400; sample_y = 8'd10;
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        sample_x = 9'(W); sample_y = 8'd3;
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        check_state("out_of_range", 16'h0000, 1'b0, 1'b0, 8'd2);

        sample_x = 9'd2; sample_y = 8'd0;
        send_frame(30, 1'b0, 16'h0000, 1'b0);
        check_state("pre_mid_reset", 16'h0002, 1'b1, 1'b0, 8'd2);
        reset_n = 1'b0;
        #2;
        check_state("async_reset", 16'h0000, 1'b0, 1'b0, 8'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        sample_x = 9'd0; sample_y = 8'd0;
        drive_beat(16'hBEEF, 1'b0, 1'b0, 1'b0);
        drive_beat(16'hCAFE, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_sop = 1'b1; in_data = 16'h7777; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
        check_state("idle_ignores_and_stall", 16'h0000, 1'b0, 1'b0, 8'd0);
    endtask

`ifdef VIDEO_PIXEL_SAMPLER_AVG_EN
    task automatic test_avg();
        apply_reset();
        sample_x = 9'd4; sample_y = 8'd0;
        for (int i = 0; i < W * H; i++)
            drive_beat((i == 4) ? 16'hF800 : ((i == 5) ? 16'h0800 : 16'h0000),
                       i == 0, i == W * H - 1, 1'b0);
        in_valid = 1'b0; in_eop = 1'b0;
        @(posedge clk); #1;
        check_state("avg_pair", 16'h8000, 1'b1, 1'b0, 8'd1);
        sample_x = 9'(W - 1); sample_y = 8'd0;
        send_frame(W * H, 1'b1, 16'h0000, 1'b0);
        check_state("avg_last_column_raw", 16'h000F, 1'b1, 1'b0, 8'd2);
    endtask
`endif

    initial begin
        sample_x = '0; sample_y = '0;
        test_reset();
        test_basic_capture();
        test_backpressure();
        test_early_eop();
        test_restart();
        test_late_eop();
        test_one_pixel_frame();
        test_out_of_range_and_reset();
`ifdef VIDEO_PIXEL_SAMPLER_AVG_EN
        test_avg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
